alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 10 +
 rtl/alu_seq.sv | 111 +++++++++++
 tb/tb_alu_seq.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Instruction handshake between an instruction producer and alu_seq.
interface alu_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [8:0] in_operand;

  modport master (output in_valid, in_opcode, in_operand, input in_ready);
  modport slave  (input in_valid, in_opcode, in_operand, output in_ready);
endinterface

// File: rtl/alu_seq.sv
// Instruction FIFO feeding an external 9-bit ALU around an accumulator.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds registered zero/neg flags.
module alu_seq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  alu_seq_if.slave   instr,
  output logic [8:0] alu_a,
  output logic [8:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [8:0] alu_out,
  output logic [8:0] acc,
  output logic       res_valid,
  output logic       busy,
  output logic       halted
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       zero,
  output logic       neg
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = 1;
  localparam logic [3:0]  OP_PASS_A = 4'b0100;
  localparam logic [3:0]  OP_NOP    = 4'b1011;
  localparam logic [3:0]  OP_HALT   = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  state_t      state;
  logic [12:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  logic [3:0]  head_op;
  logic [8:0]  head_b;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty          = (wr_ptr == rd_ptr);
  assign full           = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign instr.in_ready = !full && !halted;
  assign push           = instr.in_valid && instr.in_ready;
  assign pop            = !empty && run && (state != HALT);
  assign {head_op, head_b} = mem[rd_ptr[AW-1:0]];
  assign alu_a          = acc;
  assign busy           = (state == EXEC);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {instr.in_opcode, instr.in_operand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      halted    <= 1'b0;
      alu_op    <= OP_PASS_A;
      alu_b     <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zero      <= 1'b0;
      neg       <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      // The instruction in EXEC retires on this edge regardless of what pops next.
      if (state == EXEC && alu_op != OP_NOP) begin
        acc       <= alu_out;
        res_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        zero      <= (alu_out == 9'd0);
        neg       <= alu_out[8];
`endif
      end

      case (state)
        IDLE, EXEC: begin
          if (pop && head_op == OP_HALT) begin
            // Halt never reaches the ALU; the flush also drops any push on this edge.
            state  <= HALT;
            halted <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            alu_op <= OP_PASS_A;
            alu_b  <= '0;
          end else if (pop) begin
            state  <= EXEC;
            alu_op <= head_op;
            alu_b  <= head_b;
          end else begin
            state  <= IDLE;
            alu_op <= OP_PASS_A;
            alu_b  <= '0;
          end
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
          alu_op <= OP_PASS_A;
          alu_b  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, directed corner sequences, randomized run vs queue model.
module tb_alu_seq;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [8:0] alu_a, alu_b, alu_out, acc;
  logic [3:0] alu_op;
  logic       res_valid, busy, halted;
`ifdef ALU_SEQ_FLAGS_EN
  logic       zero, neg;
`endif

  alu_seq_if bus();

  always #5 clk = ~clk;

  alu_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .instr     (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .acc       (acc),
    .res_valid (res_valid),
    .busy      (busy),
    .halted    (halted)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  // Bench-side ALU: the environment the sequencer drives.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a;
      4'd5:    return ~a;
      4'd6:    return {a[7:0], 1'b0};
      4'd7:    return a - b;
      4'd8:    return {1'b0, a[8:1]};
      4'd9:    return b - a;
      4'd10:   return b;
      4'd11:   return a;
      default: return 9'd0;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending instructions as a queue, one instruction in flight.
  typedef struct { logic [3:0] op; logic [8:0] b; } instr_t;
  instr_t     q[$];
  instr_t     m_exec;
  bit         m_exec_v, m_rv, m_halt, m_zero, m_neg;
  logic [8:0] m_acc;

  task automatic model_reset();
    q.delete();
    m_exec_v = 0; m_rv = 0; m_halt = 0; m_zero = 0; m_neg = 0;
    m_acc = '0;
    m_exec = '{4'd0, 9'd0};
  endtask

  task automatic model_edge();
    bit     accept;
    instr_t h;
    accept = bus.in_valid && !m_halt && (q.size() < DEPTH);
    m_rv = 0;
    if (m_exec_v && m_exec.op != 4'b1011) begin
      m_acc  = alu_f(m_exec.op, m_acc, m_exec.b);
      m_rv   = 1;
      m_zero = (m_acc == 9'd0);
      m_neg  = m_acc[8];
    end
    m_exec_v = 0;
    if (!m_halt && run && q.size() > 0) begin
      h = q.pop_front();
      if (h.op == 4'b1111) begin
        m_halt = 1;
        q.delete();
      end else begin
        m_exec_v = 1;
        m_exec   = h;
      end
    end
    if (accept && !m_halt) q.push_back('{bus.in_opcode, bus.in_operand});
  endtask

  task automatic compare_all();
    chk("rnd_acc",       32'(acc),          32'(m_acc));
    chk("rnd_alu_a",     32'(alu_a),        32'(m_acc));
    chk("rnd_res_valid", 32'(res_valid),    32'(m_rv));
    chk("rnd_busy",      32'(busy),         32'(m_exec_v));
    chk("rnd_halted",    32'(halted),       32'(m_halt));
    chk("rnd_in_ready",  32'(bus.in_ready), 32'(!m_halt && q.size() < DEPTH));
    chk("rnd_alu_op",    32'(alu_op),       32'(m_exec_v ? m_exec.op : 4'b0100));
    chk("rnd_alu_b",     32'(alu_b),        32'(m_exec_v ? m_exec.b : 9'd0));
`ifdef ALU_SEQ_FLAGS_EN
    chk("rnd_zero",      32'(zero),         32'(m_zero));
    chk("rnd_neg",       32'(neg),          32'(m_neg));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_operand = 9'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct { logic [3:0] op; logic [8:0] b; logic [8:0] acc; logic rv; logic z; logic n; } vec_t;
  vec_t vec[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] acc_hold;
    logic [8:0] exp_seq[4];
    bit saw_rv, saw_halt_op, saw_busy;

    vec[0]  = '{4'b1010, 9'h005, 9'h005, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{4'b0011, 9'h003, 9'h008, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{4'b0111, 9'h009, 9'h1FF, 1'b1, 1'b0, 1'b1};
    vec[3]  = '{4'b0011, 9'h001, 9'h000, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{4'b1010, 9'h1A5, 9'h1A5, 1'b1, 1'b0, 1'b1};
    vec[5]  = '{4'b0000, 9'h0F0, 9'h0A0, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{4'b0001, 9'h10F, 9'h1AF, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{4'b0010, 9'h1FF, 9'h050, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{4'b0110, 9'h0AA, 9'h0A0, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{4'b1101, 9'h123, 9'h000, 1'b1, 1'b1, 1'b0};
    vec[10] = '{4'b1010, 9'h0FF, 9'h0FF, 1'b1, 1'b0, 1'b0};
    vec[11] = '{4'b1000, 9'h0AA, 9'h07F, 1'b1, 1'b0, 1'b0};
    vec[12] = '{4'b1011, 9'h055, 9'h07F, 1'b0, 1'b0, 1'b0};

    // Reset values
    do_reset();
    #1;
    chk("rst_acc",       32'(acc),          32'h0);
    chk("rst_res_valid", 32'(res_valid),    32'h0);
    chk("rst_halted",    32'(halted),       32'h0);
    chk("rst_busy",      32'(busy),         32'h0);
    chk("rst_alu_op",    32'(alu_op),       32'h4);
    chk("rst_alu_b",     32'(alu_b),        32'h0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'h1);
    run = 1'b1;

    // Vector table: one instruction at a time, exact two-edge latency
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_opcode = vec[i].op; bus.in_operand = vec[i].b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(vec[i].rv));
      chk($sformatf("vec%0d_acc", i),       32'(acc),       32'(vec[i].acc));
`ifdef ALU_SEQ_FLAGS_EN
      chk($sformatf("vec%0d_zero", i),      32'(zero),      32'(vec[i].z));
      chk($sformatf("vec%0d_neg", i),       32'(neg),       32'(vec[i].n));
`endif
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse_end", i), 32'(res_valid), 32'h0);
    end

    // Fill with run low, then drain back-to-back
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_opcode = 4'b0011; bus.in_operand = 9'(k + 1);
      #1 chk($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), 32'(k < 4));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("fill_busy", 32'(busy), 32'h0);
    run = 1'b1;
    exp_seq = '{9'h080, 9'h082, 9'h085, 9'h089};
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk($sformatf("drain%0d_res_valid", j), 32'(res_valid), 32'h1);
      chk($sformatf("drain%0d_acc", j),       32'(acc),       32'(exp_seq[j]));
      chk($sformatf("drain%0d_busy", j),      32'(busy),      32'(j < 3));
    end
    @(posedge clk); #1;
    chk("drain_end_res_valid", 32'(res_valid),    32'h0);
    chk("drain_end_busy",      32'(busy),         32'h0);
    chk("drain_end_in_ready",  32'(bus.in_ready), 32'h1);

    // NOP, HALT, then an instruction that must be dropped
    acc_hold = acc;
    saw_rv = 0; saw_halt_op = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus.in_valid = (c < 3) || (c >= 8 && c < 11);
      bus.in_opcode = (c == 0) ? 4'b1011 : (c == 1) ? 4'b1111 : 4'b0011;
      bus.in_operand = (c == 0) ? 9'h055 : 9'h001;
      @(posedge clk); #1;
      if (res_valid) saw_rv = 1;
      if (alu_op == 4'b1111) saw_halt_op = 1;
    end
    bus.in_valid = 1'b0;
    chk("halt_no_res_valid", 32'(saw_rv),       32'h0);
    chk("halt_alu_op_never", 32'(saw_halt_op),  32'h0);
    chk("halt_acc",          32'(acc),          32'(acc_hold));
    chk("halt_halted",       32'(halted),       32'h1);
    chk("halt_in_ready",     32'(bus.in_ready), 32'h0);
    chk("halt_busy",         32'(busy),         32'h0);
    chk("halt_alu_op",       32'(alu_op),       32'h4);

    // Asynchronous reset in the middle of EXEC
    do_reset();
    run = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = 4'b1010; bus.in_operand = 9'h033;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("mid_pre_acc", 32'(acc), 32'h033);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = 4'b0011; bus.in_operand = 9'h010;
    @(negedge clk);
    bus.in_operand = 9'h020;
    @(posedge clk); #1;
    chk("mid_busy_before", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_acc",    32'(acc),    32'h0);
    chk("mid_busy",   32'(busy),   32'h0);
    chk("mid_alu_op", 32'(alu_op), 32'h4);
    chk("mid_alu_b",  32'(alu_b),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rv = 0; saw_busy = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (res_valid) saw_rv = 1;
      if (busy) saw_busy = 1;
    end
    chk("mid_after_res_valid", 32'(saw_rv),   32'h0);
    chk("mid_after_busy",      32'(saw_busy), 32'h0);
    chk("mid_after_acc",       32'(acc),      32'h0);

    // Randomized segments against the queue model
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        run = ($urandom_range(0, 3) != 0);
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_opcode = ($urandom_range(0, 99) < 1) ? 4'b1111 : 4'($urandom_range(0, 14));
        bus.in_operand = 9'($urandom);
        @(posedge clk);
        model_edge();
        #1 compare_all();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
